button_event_decoder: RTL and testbench

- Consumes a clean, debounced, clk-synchronous button level and classifies each press for the clock's time-setting logic.
- Classifications: press start, short press (released before threshold), long press (held to threshold), and auto-repeat while held.
- Sits between the button conditioning stage and the set-mode/increment control logic.
- Emits single-cycle event pulses only, so downstream counters advance once per event.

---
 rtl/button_event_decoder.sv | 128 ++++++++++++
 tb/tb_button_event_decoder.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/button_event_decoder.sv
// Classifies a debounced button level into press/short/long/auto-repeat event pulses.
// All outputs are registered single-cycle pulses except held, which is a level.
module button_event_decoder #(
  parameter int unsigned TICK_COUNT   = 100000,
  parameter int unsigned LONG_TICKS   = 1000,
  parameter int unsigned REPEAT_TICKS = 200
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_level,
  output logic press_pulse,
  output logic short_press,
  output logic long_press,
  output logic repeat_pulse,
  output logic held
);

  localparam int unsigned PreW  = $clog2(TICK_COUNT + 1);
  localparam int unsigned HoldW = $clog2(LONG_TICKS + 1);
  localparam int unsigned RepW  = $clog2(REPEAT_TICKS + 1);

  typedef enum logic [1:0] {StIdle, StPressed, StLongHeld} state_e;

  state_e            state_q, state_d;
  logic [PreW-1:0]   presc_q, presc_d;
  logic [HoldW-1:0]  hold_q, hold_d;
  logic [RepW-1:0]   rep_q, rep_d;
  logic              press_q, press_d;
  logic              short_q, short_d;
  logic              long_q, long_d;
  logic              repeat_q, repeat_d;
  logic              held_q, held_d;
  logic              tick;

  assign tick = (presc_q == PreW'(TICK_COUNT - 1));

  always_comb begin
    state_d  = state_q;
    presc_d  = presc_q;
    hold_d   = hold_q;
    rep_d    = rep_q;
    press_d  = 1'b0;
    short_d  = 1'b0;
    long_d   = 1'b0;
    repeat_d = 1'b0;
    case (state_q)
      StIdle: begin
        presc_d = '0;
        if (btn_level) begin
          state_d = StPressed;
          press_d = 1'b1;
          hold_d  = '0;
        end
      end
      StPressed: begin
        // Release is checked first so it wins over a coincident threshold tick.
        if (!btn_level) begin
          state_d = StIdle;
          short_d = 1'b1;
          presc_d = '0;
        end else if (tick) begin
          presc_d = '0;
          if (hold_q == HoldW'(LONG_TICKS - 1)) begin
            state_d = StLongHeld;
            long_d  = 1'b1;
            rep_d   = '0;
          end else begin
            hold_d = hold_q + HoldW'(1);
          end
        end else begin
          presc_d = presc_q + PreW'(1);
        end
      end
      StLongHeld: begin
        if (!btn_level) begin
          state_d = StIdle;
          presc_d = '0;
        end else if (tick) begin
          presc_d = '0;
          if (rep_q == RepW'(REPEAT_TICKS - 1)) begin
            repeat_d = 1'b1;
            rep_d    = '0;
          end else begin
            rep_d = rep_q + RepW'(1);
          end
        end else begin
          presc_d = presc_q + PreW'(1);
        end
      end
      default: begin
        state_d = StIdle;
        presc_d = '0;
      end
    endcase
    held_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      presc_q  <= '0;
      hold_q   <= '0;
      rep_q    <= '0;
      press_q  <= 1'b0;
      short_q  <= 1'b0;
      long_q   <= 1'b0;
      repeat_q <= 1'b0;
      held_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      hold_q   <= hold_d;
      rep_q    <= rep_d;
      press_q  <= press_d;
      short_q  <= short_d;
      long_q   <= long_d;
      repeat_q <= repeat_d;
      held_q   <= held_d;
    end
  end

  assign press_pulse  = press_q;
  assign short_press  = short_q;
  assign long_press   = long_q;
  assign repeat_pulse = repeat_q;
  assign held         = held_q;

endmodule

// File: tb/tb_button_event_decoder.sv
// Scoreboard bench: stimulus pushes expected {cycle, outputs} events, monitors pop and compare.
module tb_button_event_decoder;

  typedef struct packed {
    int unsigned cyc;
    logic [4:0]  vec;  // {held, press, short, long, repeat}
  } ev_t;

  localparam logic [4:0] VPress  = 5'b11000;
  localparam logic [4:0] VShort  = 5'b00100;
  localparam logic [4:0] VLong   = 5'b10010;
  localparam logic [4:0] VRepeat = 5'b10001;
  localparam logic [4:0] VDrop   = 5'b00000;

  logic clk = 1'b0;
  logic reset;
  logic btn_a, btn_b;
  logic press_a, short_a, long_a, rep_a, held_a;
  logic press_b, short_b, long_b, rep_b, held_b;
  logic prev_held_a = 1'b0;
  logic prev_held_b = 1'b0;

  int unsigned cyc = 0;
  int unsigned base;
  int checks = 0;
  int errors = 0;
  ev_t q_a[$];
  ev_t q_b[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  button_event_decoder #(.TICK_COUNT(4), .LONG_TICKS(3), .REPEAT_TICKS(2)) dut_a (
    .clk         (clk),
    .reset       (reset),
    .btn_level   (btn_a),
    .press_pulse (press_a),
    .short_press (short_a),
    .long_press  (long_a),
    .repeat_pulse(rep_a),
    .held        (held_a)
  );

  button_event_decoder #(.TICK_COUNT(1), .LONG_TICKS(1), .REPEAT_TICKS(1)) dut_b (
    .clk         (clk),
    .reset       (reset),
    .btn_level   (btn_b),
    .press_pulse (press_b),
    .short_press (short_b),
    .long_press  (long_b),
    .repeat_pulse(rep_b),
    .held        (held_b)
  );

  task automatic check(string nm, int got, int req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", nm, got, req);
    end
  endtask

  task automatic compare_ev(string nm, ev_t exp, int unsigned now, logic [4:0] got);
    checks++;
    if (exp.cyc != now || exp.vec !== got) begin
      errors++;
      $display("FAIL %s event: got cycle %0d outputs %b, required cycle %0d outputs %b",
               nm, now, got, exp.cyc, exp.vec);
    end
  endtask

  task automatic unexpected(string nm, logic [4:0] got);
    checks++;
    errors++;
    $display("FAIL %s unexpected event: got cycle %0d outputs %b, required none", nm, cyc, got);
  endtask

  // Monitors fire on any pulse or any change of held.
  always @(negedge clk) begin
    if ({press_a, short_a, long_a, rep_a} != 4'b0 || held_a != prev_held_a) begin
      if (q_a.size() == 0) unexpected("dut_a", {held_a, press_a, short_a, long_a, rep_a});
      else compare_ev("dut_a", q_a.pop_front(), cyc, {held_a, press_a, short_a, long_a, rep_a});
    end
    prev_held_a <= held_a;
  end

  always @(negedge clk) begin
    if ({press_b, short_b, long_b, rep_b} != 4'b0 || held_b != prev_held_b) begin
      if (q_b.size() == 0) unexpected("dut_b", {held_b, press_b, short_b, long_b, rep_b});
      else compare_ev("dut_b", q_b.pop_front(), cyc, {held_b, press_b, short_b, long_b, rep_b});
    end
    prev_held_b <= held_b;
  end

  task automatic exp_a(int unsigned off, logic [4:0] v);
    q_a.push_back('{cyc: base + off, vec: v});
  endtask

  task automatic exp_b(int unsigned off, logic [4:0] v);
    q_b.push_back('{cyc: base + off, vec: v});
  endtask

  // Raise the level at a negedge; base becomes the edge that samples it high.
  task automatic rise_a();
    @(negedge clk);
    btn_a = 1'b1;
    base  = cyc + 1;
  endtask

  task automatic hold_release_a(int n);
    repeat (n) @(negedge clk);
    btn_a = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    btn_a = 1'b0;
    btn_b = 1'b0;
    #3;
    check("reset outputs a", int'({held_a, press_a, short_a, long_a, rep_a}), 0);
    check("reset outputs b", int'({held_b, press_b, short_b, long_b, rep_b}), 0);
    repeat (2) @(negedge clk);
    check("reset held outputs a", int'({held_a, press_a, short_a, long_a, rep_a}), 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Short press, 5 cycles high.
    rise_a();
    exp_a(0, VPress);
    exp_a(5, VShort);
    hold_release_a(5);

    // Long press with three repeats, 40 cycles high.
    rise_a();
    exp_a(0, VPress);
    exp_a(12, VLong);
    exp_a(20, VRepeat);
    exp_a(28, VRepeat);
    exp_a(36, VRepeat);
    exp_a(40, VDrop);
    hold_release_a(40);

    // Release on the threshold edge: short wins.
    rise_a();
    exp_a(0, VPress);
    exp_a(12, VShort);
    hold_release_a(12);

    // One cycle longer: long, and no short on release.
    rise_a();
    exp_a(0, VPress);
    exp_a(12, VLong);
    exp_a(13, VDrop);
    hold_release_a(13);

    // Reset while in long-held, level still high across reset.
    rise_a();
    exp_a(0, VPress);
    exp_a(12, VLong);
    repeat (16) @(negedge clk);
    #1 reset = 1'b1;
    #1;
    check("async reset held", int'(held_a), 0);
    check("async reset pulses", int'({press_a, short_a, long_a, rep_a}), 0);
    exp_a(16, VDrop);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    base = cyc + 1;
    exp_a(0, VPress);
    exp_a(12, VLong);
    exp_a(15, VDrop);
    hold_release_a(15);

    // Back-to-back single-cycle presses.
    rise_a();
    exp_a(0, VPress);
    exp_a(1, VShort);
    exp_a(2, VPress);
    exp_a(3, VShort);
    @(negedge clk);
    btn_a = 1'b0;
    @(negedge clk);
    btn_a = 1'b1;
    @(negedge clk);
    btn_a = 1'b0;
    repeat (6) @(negedge clk);

    // Minimal parameters: long after one cycle, repeat every cycle.
    @(negedge clk);
    btn_b = 1'b1;
    base  = cyc + 1;
    exp_b(0, VPress);
    exp_b(1, VLong);
    exp_b(2, VRepeat);
    exp_b(3, VRepeat);
    exp_b(4, VRepeat);
    exp_b(5, VRepeat);
    exp_b(6, VDrop);
    repeat (6) @(negedge clk);
    btn_b = 1'b0;

    repeat (10) @(negedge clk);
    check("dut_a events outstanding", q_a.size(), 0);
    check("dut_b events outstanding", q_b.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
